permute_stage: RTL and testbench
================================

# permute_stage

Parametrised, handshaked lane-permutation stage for the pipelined cipher datapath. It reorders `LANES` lanes of `LANE_W` bits each, using one of four key-selected permutations, with an optional inverse (decrypt) path. It sits between the substitution and mixing stages. It replaces enable/tri-state gating with a valid/ready interface and a 2-entry skid buffer, and keeps full throughput under backpressure.

## Interface
- `LANES`, default 4: lane count; power of two, ≥4.
- `LANE_W`, default 8: bits per lane.
- `CNT_W`, default 16: width of the beat counter.
- `clk` input, 1 bit: the single clock. All logic is on its rising edge.
- `reset_n` input, 1 bit: reset, synchronous and active-low.
- `in_valid` input, 1 bit: input beat present.
- `in_ready` output, 1 bit: stage can accept a beat.
- `in_data` input, `LANES*LANE_W` bits: lane i is bits `[i*LANE_W +: LANE_W]`.
- `in_sel` input, 2 bits: permutation select (`perm_sel_e`), sampled with the beat.
- `in_dec` input, 1 bit: apply the inverse permutation. Ignored unless `PERMUTE_INVERSE_EN` is defined.
- `out_valid` output, 1 bit: output beat present.
- `out_ready` input, 1 bit: the downstream stage accepts the beat.
- `out_data` output, `LANES*LANE_W` bits: permuted beat.
- `beat_count` output, `CNT_W` bits: number of output transfers.

## Operation
- A transfer happens when `valid && ready` on a port. The permutation is applied on the input side and registered. The input a and output w are defined per lane i, with arithmetic mod `LANES`:
  - `PERM_SWAP` (0): w[i] = a[i^1].
  - `PERM_REV` (1): w[i] = a[LANES-1-i].
  - `PERM_ROTL` (2): w[i] = a[i+1].
  - `PERM_ROTR` (3): w[i] = a[i-1].
- Inverse mode (`in_dec`=1) swaps ROTL and ROTR. SWAP and REV are self-inverse.
- Storage is an output register (`out_valid`/`out_data`) plus one skid register.
- On an accepted beat:
  - If the output register is empty, or `out_ready`=1 and skid is empty, the beat loads into the output register.
  - Otherwise it loads into skid.
- When the output transfers and skid is full, skid moves to the output register in the same cycle.
- `in_ready` = skid empty, driven from a register (no combinational path from `out_ready`).
- Beats leave in arrival order. None are dropped or duplicated.
- `beat_count` increments on each output transfer and wraps from 2^CNT_W−1 to 0.
- Outputs are never driven to Z.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, skid empty, `beat_count`=0.
- `in_ready`=0 while `reset_n`=0. Beats offered during reset are discarded. `in_ready`=1 from the first cycle after release.
- Latency is 1 cycle: a beat accepted at edge n is on `out_data` with `out_valid`=1 after edge n.
- Throughput is 1 beat/cycle with `out_ready` held high.
- If `out_ready` goes low with a beat in the output register, the next accepted beat fills skid and `in_ready` falls the cycle after.
- Simultaneous input accept, output transfer and full skid cannot occur, because `in_ready`=0 whenever skid is full.
- Reset mid-stream: contents are flushed on the reset edge and the count clears. No partial beat is emitted.
- `out_data` and `out_valid` hold stable while `out_valid`=1 and `out_ready`=0.

## Configuration
- `PERMUTE_INVERSE_EN` defined: `in_dec` is honoured as above.
- `PERMUTE_INVERSE_EN` undefined: the inverse logic is compiled out, `in_dec` is ignored, and behaviour is as if `in_dec`=0.

## Structure
- `permute_pkg` holds:
  - `typedef enum logic [1:0] perm_sel_e {PERM_SWAP, PERM_REV, PERM_ROTL, PERM_ROTR}`
  - the inverse-select mapping function.
- Sub-module `permute_net`: purely combinational lane mapping, parametrised by `LANES`/`LANE_W`, taking sel and dec. It is instantiated once at the input, and the skid logic stays in `permute_stage`.

## Test plan
Defaults throughout; `in_data`=0x44332211 (lane0=0x11).
- Send `in_sel`=0, 1, 2, 3 back-to-back with `out_ready`=1. Expect `out_data` = 0x33441122, 0x11223344, 0x11443322, 0x33221144 on consecutive cycles, each 1 cycle after accept; `beat_count`=4.
- With `PERMUTE_INVERSE_EN` defined, send `in_sel`=2, `in_dec`=1. Expect 0x33221144. Send `in_sel`=0, `in_dec`=1. Expect 0x33441122. With the macro undefined, `in_sel`=2, `in_dec`=1 gives 0x11443322.
- Hold `out_ready`=0 and offer beats A, B, C. Expect A and B accepted, `in_ready`=0 from the cycle after B, C held. Raise `out_ready`. Expect A, B, C out in order on 3 consecutive cycles and `out_data` stable while stalled.
- Assert `reset_n`=0 for one cycle with both registers full. Expect `out_valid`=0, `out_data`=0, `beat_count`=0 after the edge, and `in_ready`=1 the cycle after release.
- Instantiate with `CNT_W`=4 and stream 17 beats. Expect `beat_count` to wrap to 0 after 16 beats and end at 1.
- Instantiate with `LANES`=8, `in_sel`=3, lanes 0..7 = 0x00..0x07. Expect lane i = (i−1) mod 8, i.e. `out_data`=0x0605040302010007.

Source files
------------

// File: rtl/permute_pkg.sv
// Shared types for the lane-permutation stage: permutation selector and the
// mapping that turns a forward selector into its inverse for decrypt beats.
package permute_pkg;

  typedef enum logic [1:0] {
    PERM_SWAP = 2'd0,
    PERM_REV  = 2'd1,
    PERM_ROTL = 2'd2,
    PERM_ROTR = 2'd3
  } perm_sel_e;

  // SWAP and REV undo themselves; the two rotations undo each other.
  function automatic perm_sel_e inv_sel(perm_sel_e sel, logic dec);
    perm_sel_e r;
    r = sel;
    if (dec) begin
      case (sel)
        PERM_ROTL: r = PERM_ROTR;
        PERM_ROTR: r = PERM_ROTL;
        default:   r = sel;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/permute_net.sv
// Combinational lane mapping: w[i] = a[src(i)], with lane indices taken
// mod LANES. Build option: define PERMUTE_INVERSE_EN to honour dec (inverse
// permutation); without it dec has no effect.
module permute_net
  import permute_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int LANE_W = 8
) (
  input  logic [LANES*LANE_W-1:0] a,
  input  perm_sel_e               sel,
  input  logic                    dec,
  output logic [LANES*LANE_W-1:0] w
);

  localparam int IDX_W = $clog2(LANES);

  perm_sel_e eff_sel;

`ifdef PERMUTE_INVERSE_EN
  assign eff_sel = inv_sel(sel, dec);
`else
  logic unused_dec;
  assign unused_dec = dec;
  assign eff_sel    = sel;
`endif

  // Index arithmetic is done at IDX_W bits so wrap-around is free (LANES is a power of two).
  always_comb begin
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] src;
    w   = '0;
    idx = '0;
    src = '0;
    for (int i = 0; i < LANES; i++) begin
      idx = IDX_W'(i);
      case (eff_sel)
        PERM_SWAP: src = idx ^ IDX_W'(1);
        PERM_REV:  src = ~idx;
        PERM_ROTL: src = idx + IDX_W'(1);
        default:   src = idx - IDX_W'(1);
      endcase
      w[i*LANE_W +: LANE_W] = a[int'(src)*LANE_W +: LANE_W];
    end
  end

endmodule

// File: rtl/permute_stage.sv
// Handshaked lane-permutation stage: permutes on the input side, then holds
// beats in an output register plus one skid register so in_ready can be a
// flop. Build option: PERMUTE_INVERSE_EN enables the in_dec inverse path.
module permute_stage
  import permute_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int LANE_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*LANE_W-1:0] in_data,
  input  logic [1:0]              in_sel,
  input  logic                    in_dec,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] out_data,
  output logic [CNT_W-1:0]        beat_count
);

  localparam int DW = LANES * LANE_W;

  if (LANES < 4 || (LANES & (LANES - 1)) != 0) begin : g_bad_lanes
    $error("permute_stage: LANES must be a power of two >= 4");
  end

  logic [DW-1:0] perm_p0;
  logic          in_rdy_q;
  logic          skid_vld_p1;
  logic [DW-1:0] skid_data_p1;
  logic          in_fire;
  logic          out_fire;
  logic          out_vld_nxt;
  logic [DW-1:0] out_data_nxt;
  logic          skid_vld_nxt;
  logic [DW-1:0] skid_data_nxt;

  permute_net #(
    .LANES  (LANES),
    .LANE_W (LANE_W)
  ) u_net (
    .a   (in_data),
    .sel (perm_sel_e'(in_sel)),
    .dec (in_dec),
    .w   (perm_p0)
  );

  // reset_n gates the flop so beats offered while in reset are never taken.
  assign in_ready = in_rdy_q & reset_n;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Next-state of the two-entry buffer; in_fire implies skid is empty.
  always_comb begin
    out_vld_nxt   = out_valid;
    out_data_nxt  = out_data;
    skid_vld_nxt  = skid_vld_p1;
    skid_data_nxt = skid_data_p1;
    if (out_fire) begin
      if (skid_vld_p1) begin
        out_data_nxt = skid_data_p1;
        skid_vld_nxt = 1'b0;
      end else begin
        out_vld_nxt = 1'b0;
      end
    end
    if (in_fire) begin
      if (!out_valid || (out_ready && !skid_vld_p1)) begin
        out_vld_nxt  = 1'b1;
        out_data_nxt = perm_p0;
      end else begin
        skid_vld_nxt  = 1'b1;
        skid_data_nxt = perm_p0;
      end
    end
  end

  // ---- stage p1: output register, skid flags, ready flop and beat counter ----
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      skid_vld_p1 <= 1'b0;
      in_rdy_q    <= 1'b0;
      beat_count  <= '0;
    end else begin
      out_valid   <= out_vld_nxt;
      out_data    <= out_data_nxt;
      skid_vld_p1 <= skid_vld_nxt;
      in_rdy_q    <= ~skid_vld_nxt;
      if (out_fire) beat_count <= beat_count + CNT_W'(1);
    end
  end

  // Skid payload is only meaningful while skid_vld_p1 is set, so it needs no reset.
  always_ff @(posedge clk) begin
    skid_data_p1 <= skid_data_nxt;
  end

endmodule

// File: tb/tb_permute_stage.sv
module tb_permute_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  // default instance
  logic        in_valid, in_ready, in_dec, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [1:0]  in_sel;
  logic [15:0] beat_count;
  // CNT_W=4 instance
  logic        c_in_valid, c_in_ready, c_in_dec, c_out_valid, c_out_ready;
  logic [31:0] c_in_data, c_out_data;
  logic [1:0]  c_in_sel;
  logic [3:0]  c_beat_count;
  // LANES=8 instance
  logic        l_in_valid, l_in_ready, l_in_dec, l_out_valid, l_out_ready;
  logic [63:0] l_in_data, l_out_data;
  logic [1:0]  l_in_sel;
  logic [15:0] l_beat_count;

  int total = 0;
  int bad   = 0;

  logic [63:0] q[$];
  logic [15:0] exp_cnt = '0;
  bit          rst_prev = 1'b1;

  always #5 clk = ~clk;

  permute_stage dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .in_dec(in_dec), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .beat_count(beat_count)
  );

  permute_stage #(.CNT_W(4)) dut_c (
    .clk(clk), .reset_n(reset_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .in_sel(c_in_sel), .in_dec(c_in_dec), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_data(c_out_data), .beat_count(c_beat_count)
  );

  permute_stage #(.LANES(8)) dut_l (
    .clk(clk), .reset_n(reset_n), .in_valid(l_in_valid), .in_ready(l_in_ready),
    .in_data(l_in_data), .in_sel(l_in_sel), .in_dec(l_in_dec), .out_valid(l_out_valid),
    .out_ready(l_out_ready), .out_data(l_out_data), .beat_count(l_beat_count)
  );

  // Reference permutation straight from the lane rules, 8-bit lanes.
  function automatic logic [63:0] model_perm(logic [63:0] a, int sel, bit dec, int lanes);
    logic [63:0] r;
    int s;
    int src;
    r = '0;
    s = sel;
`ifdef PERMUTE_INVERSE_EN
    if (dec && s == 2) s = 3;
    else if (dec && s == 3) s = 2;
`endif
    for (int i = 0; i < lanes; i++) begin
      case (s)
        0:       src = i ^ 1;
        1:       src = lanes - 1 - i;
        2:       src = (i + 1) % lanes;
        default: src = (i + lanes - 1) % lanes;
      endcase
      r[i*8 +: 8] = a[src*8 +: 8];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of the default instance with scoreboard checks; returns whether the input beat was taken.
  task automatic cycle(output bit fired);
    bit          fin, fout;
    logic [63:0] pend;
    @(negedge clk);
    fin  = in_valid && in_ready;
    fout = out_valid && out_ready;
    pend = model_perm({32'h0, in_data}, int'(in_sel), in_dec, 4);
    check("in_ready", {63'h0, in_ready}, {63'h0, (reset_n && !rst_prev && q.size() < 2)});
    check("out_valid", {63'h0, out_valid}, {63'h0, (q.size() > 0)});
    if (q.size() > 0) check("out_data", {32'h0, out_data}, q[0]);
    check("beat_count", {48'h0, beat_count}, {48'h0, exp_cnt});
    @(posedge clk);
    #1;
    if (!reset_n) begin
      q.delete();
      exp_cnt = '0;
    end else begin
      if (fout) begin
        void'(q.pop_front());
        exp_cnt++;
      end
      if (fin) q.push_back(pend);
    end
    rst_prev = !reset_n;
    fired = fin;
  endtask

  initial begin
    bit          f;
    logic [31:0] vec[4];
    logic [63:0] ea, eb, ec;
    vec[0] = 32'h33441122; vec[1] = 32'h11223344;
    vec[2] = 32'h11443322; vec[3] = 32'h33221144;

    reset_n = 1'b0;
    in_valid = 1'b1; in_data = $urandom; in_sel = 2'd1; in_dec = 1'b0; out_ready = 1'b1;
    c_in_valid = 1'b0; c_in_data = 32'h44332211; c_in_sel = 2'd0; c_in_dec = 1'b0; c_out_ready = 1'b1;
    l_in_valid = 1'b0; l_in_data = '0; l_in_sel = 2'd0; l_in_dec = 1'b0; l_out_ready = 1'b1;

    // reset with a beat offered: it must be discarded
    cycle(f);
    cycle(f);
    check("rst_out_valid", {63'h0, out_valid}, 64'h0);
    check("rst_out_data", {32'h0, out_data}, 64'h0);
    check("rst_count", {48'h0, beat_count}, 64'h0);
    check("rst_in_ready", {63'h0, in_ready}, 64'h0);
    reset_n = 1'b1;
    in_valid = 1'b0;
    cycle(f);
    check("ready_after_release", {63'h0, in_ready}, 64'h1);

    // four permutations back to back
    in_data = 32'h44332211;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_sel = 2'(k);
      cycle(f);
      check($sformatf("sel%0d_data", k), {32'h0, out_data}, {32'h0, vec[k]});
      check($sformatf("sel%0d_valid", k), {63'h0, out_valid}, 64'h1);
    end
    in_valid = 1'b0;
    cycle(f);
    check("count_after_4", {48'h0, beat_count}, 64'd4);

    // inverse path
    in_valid = 1'b1; in_sel = 2'd2; in_dec = 1'b1;
    cycle(f);
`ifdef PERMUTE_INVERSE_EN
    check("dec_rotl", {32'h0, out_data}, 64'h33221144);
`else
    check("dec_rotl_ignored", {32'h0, out_data}, 64'h11443322);
`endif
    in_sel = 2'd0;
    cycle(f);
    check("dec_swap", {32'h0, out_data}, 64'h33441122);
    in_valid = 1'b0; in_dec = 1'b0;
    cycle(f);

    // stall: A and B taken, C held
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 32'hA4A3A2A1; in_sel = 2'd1;
    ea = model_perm({32'h0, in_data}, 1, 1'b0, 4);
    cycle(f);
    in_data = 32'hB4B3B2B1; in_sel = 2'd2;
    eb = model_perm({32'h0, in_data}, 2, 1'b0, 4);
    cycle(f);
    check("stall_ready_low", {63'h0, in_ready}, 64'h0);
    in_data = 32'hC4C3C2C1; in_sel = 2'd3;
    ec = model_perm({32'h0, in_data}, 3, 1'b0, 4);
    for (int k = 0; k < 3; k++) begin
      cycle(f);
      check("stall_hold_data", {32'h0, out_data}, ea);
      check("stall_hold_ready", {63'h0, in_ready}, 64'h0);
    end
    out_ready = 1'b1;
    cycle(f);
    check("drain_b", {32'h0, out_data}, eb);
    f = 1'b0;
    for (int k = 0; k < 4 && !f; k++) cycle(f);
    check("c_accepted", {63'h0, f}, 64'h1);
    in_valid = 1'b0;
    check("drain_c", {32'h0, out_data}, ec);
    cycle(f);
    check("drained", {63'h0, out_valid}, 64'h0);

    // reset with both registers full
    out_ready = 1'b0;
    in_valid = 1'b1;
    cycle(f);
    cycle(f);
    check("full_ready_low", {63'h0, in_ready}, 64'h0);
    reset_n = 1'b0;
    cycle(f);
    check("midrst_valid", {63'h0, out_valid}, 64'h0);
    check("midrst_data", {32'h0, out_data}, 64'h0);
    check("midrst_count", {48'h0, beat_count}, 64'h0);
    reset_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    cycle(f);
    check("midrst_ready", {63'h0, in_ready}, 64'h1);

    // counter wrap with CNT_W=4
    c_in_valid = 1'b1;
    repeat (16) begin @(posedge clk); #1; end
    check("wrap_15", {60'h0, c_beat_count}, 64'd15);
    @(posedge clk); #1;
    check("wrap_0", {60'h0, c_beat_count}, 64'd0);
    c_in_valid = 1'b0;
    @(posedge clk); #1;
    check("wrap_1", {60'h0, c_beat_count}, 64'd1);
    check("wrap_ready", {63'h0, c_in_ready}, 64'h1);
    check("wrap_last_data", {32'h0, c_out_data}, 64'h33441122);
    check("wrap_valid_low", {63'h0, c_out_valid}, 64'h0);

    // eight lanes, rotate right
    l_in_data = 64'h0706050403020100; l_in_sel = 2'd3; l_in_valid = 1'b1;
    @(posedge clk); #1;
    l_in_valid = 1'b0;
    check("l8_rotr", l_out_data, 64'h0605040302010007);
    check("l8_model", l_out_data, model_perm(64'h0706050403020100, 3, 1'b0, 8));
    check("l8_valid", {63'h0, l_out_valid}, 64'h1);
    @(posedge clk); #1;
    check("l8_count", {48'h0, l_beat_count}, 64'd1);
    check("l8_ready", {63'h0, l_in_ready}, 64'h1);

    // randomized traffic against the queue model
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 6);
      in_data   = $urandom;
      in_sel    = 2'($urandom_range(0, 3));
      in_dec    = 1'($urandom_range(0, 1));
      cycle(f);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) cycle(f);
    check("final_empty", {63'h0, out_valid}, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
